// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Shares one combinational ALU between two requesters. A round-robin arbiter
// picks a requester in IDLE, the 4-bit op is decoded into the ALU's 3-bit
// control word, and the operands are held stable on alu_a/alu_b/alu_ctrl for an
// op-dependent number of cycles. The result is then captured and returned with
// a valid/ready response that carries the requester ID.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   req_valid   [1:0]        per-requester request valid
//   req_ready   [1:0]        per-requester accept (one-hot or zero)
//   req_op      [7:0]        {op1, op0}
//   req_a       [2*WIDTH-1:0] {a1, a0}
//   req_b       [2*WIDTH-1:0] {b1, b0}
//   alu_a/alu_b [WIDTH-1:0]  operands to the ALU (registered)
//   alu_ctrl    [2:0]        ALU control word (registered)
//   alu_result  [WIDTH-1:0]  combinational ALU result
//   rsp_valid/rsp_ready      response handshake
//   rsp_id                   requester that issued the op
//   rsp_data    [WIDTH-1:0]  captured result
//   rsp_err                  unsupported op or divide by zero
//   busy                     high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int WIDTH   = 32,
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [7:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   alu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             rr_ptr;
  logic [CW-1:0]    cnt;
  logic             id_q;
  logic             unsup_q;
  logic             div0_q;

  // Arbitration and decode of the granted request.
  logic             g;
  logic             accept;
  logic [3:0]       op_g;
  logic [WIDTH-1:0] a_g;
  logic [WIDTH-1:0] b_g;
  logic [2:0]       ctrl_g;
  int               lat_g;
  logic             unsup_g;
  logic             div0_g;
  logic [CW-1:0]    cnt_load;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    // The pointer's requester wins if it asks; otherwise the other one.
    g = rr_ptr;
    if (!req_valid[rr_ptr]) g = ~rr_ptr;

    op_g = g ? req_op[7:4]             : req_op[3:0];
    a_g  = g ? req_a[2*WIDTH-1:WIDTH]  : req_a[WIDTH-1:0];
    b_g  = g ? req_b[2*WIDTH-1:WIDTH]  : req_b[WIDTH-1:0];

    ctrl_g  = 3'b000;
    lat_g   = 1;
    unsup_g = 1'b0;
    case (op_g)
      4'h0: begin ctrl_g = 3'b000; lat_g = ADD_LAT; end
      4'h1: begin ctrl_g = 3'b001; lat_g = ADD_LAT; end
      4'h2: begin ctrl_g = 3'b010; lat_g = MUL_LAT; end
      4'h3: begin ctrl_g = 3'b011; lat_g = DIV_LAT; end
      default: unsup_g = 1'b1;
    endcase
    div0_g   = (op_g == 4'h3) && (b_g == '0);
    cnt_load = CW'(lat_g - 1);

    // Gated with rst so no accept is advertised while reset is held.
    accept    = (state == IDLE) && req_valid[g] && !rst;
    req_ready = 2'b00;
    if (accept) req_ready[g] = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = EXEC;
      EXEC:    if (cnt == '0) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is asynchronous and clears all of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      cnt       <= '0;
      id_q      <= 1'b0;
      unsup_q   <= 1'b0;
      div0_q    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= 3'b000;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a    <= a_g;
            alu_b    <= b_g;
            alu_ctrl <= ctrl_g;
            id_q     <= g;
            unsup_q  <= unsup_g;
            div0_q   <= div0_g;
            cnt      <= cnt_load;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            // Error cases override whatever the ALU produced.
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_err   <= unsup_q | div0_q;
            if (unsup_q)     rsp_data <= '0;
            else if (div0_q) rsp_data <= '1;
            else             rsp_data <= alu_result;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= ~rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
